// File: rtl/tdm_i2s_unit.sv
// Serial audio output unit: buffers CHANNELS-sample frames in a FIFO and
// serialises them as I2S, left-justified or TDM (DSP pulse) on sck/ws/sdo.
module tdm_i2s_unit #(
    parameter int SAMPLE_W   = 24,
    parameter int SLOT_W     = 32,
    parameter int CHANNELS   = 2,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         play_in,
    input  logic                         cfg_in,
    input  logic [31:0]                  cfg_reg_in,
    input  logic                         tick_in,
    input  logic [CHANNELS*SAMPLE_W-1:0] audio_in,
    output logic                         req_out,
    output logic                         sck_out,
    output logic                         ws_out,
    output logic                         sdo_out,
    output logic                         underrun_out,
    output logic                         overflow_out
);
    localparam int FRAME = CHANNELS * SLOT_W;
    localparam int DW    = CHANNELS * SAMPLE_W;
    localparam int BW    = $clog2(FRAME);
    localparam int AW    = $clog2(FIFO_DEPTH);
    localparam logic [1:0] MODE_LJ  = 2'b01;
    localparam logic [1:0] MODE_TDM = 2'b10;

    logic [3:0]    cfg_q, cfg_d;
    logic          play_q, play_d;
    logic [4:0]    cnt_q, cnt_d;
    logic [BW-1:0] b_q, b_d;
    logic [DW-1:0] frame_q, frame_d;
    logic          lj_q, lj_d;
    logic          sck_q, sck_d, ws_q, ws_d, sdo_q, sdo_d;
    logic          req_q, req_d, underrun_q, underrun_d, overflow_q, overflow_d;
    logic [AW:0]   wr_q, wr_d, rd_q, rd_d, wr_base;
    logic [DW-1:0] mem_q [FIFO_DEPTH];
    logic [DW-1:0] mem_d [FIFO_DEPTH];

    logic [4:0] div_m1, half_m1;
    logic       empty, full, fall, start, pop, push, flush, update;
    logic       mode_i2s, mode_tdm;
    logic       unused_cfg;

    assign unused_cfg = ^cfg_reg_in[31:4];

    // LJ bit for frame position b: MSB first, left-aligned in its slot, zero padded
    function automatic logic ser_bit(input logic [DW-1:0] d, input logic [BW-1:0] b);
        int unsigned k, idx;
        logic [DW-1:0] sh;
        k   = int'(b) % SLOT_W;
        idx = (int'(b) / SLOT_W) * SAMPLE_W + SAMPLE_W - 1 - ((k < SAMPLE_W) ? k : 0);
        sh  = d >> idx;
        return (k < SAMPLE_W) ? sh[0] : 1'b0;
    endfunction

    assign div_m1   = 5'((6'd4 << cfg_q[1:0]) - 6'd1);
    assign half_m1  = 5'((6'd2 << cfg_q[1:0]) - 6'd1);
    assign mode_tdm = (cfg_q[3:2] == MODE_TDM);
    assign mode_i2s = (cfg_q[3:2] != MODE_LJ) && !mode_tdm;
    assign empty    = (wr_q == rd_q);
    assign full     = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign fall     = play_q && (cnt_q == div_m1);
    assign start    = play_in && (!play_q || (fall && b_q == BW'(FRAME - 1)));
    assign pop      = start && !empty;
    assign push     = tick_in && (!full || pop);
    assign flush    = !play_in && play_q;

    always_comb begin
        cfg_d      = cfg_q;
        play_d     = play_in;
        cnt_d      = cnt_q;
        b_d        = b_q;
        frame_d    = frame_q;
        lj_d       = lj_q;
        sck_d      = sck_q;
        ws_d       = ws_q;
        sdo_d      = sdo_q;
        req_d      = 1'b0;
        underrun_d = 1'b0;
        overflow_d = tick_in && !push;
        mem_d      = mem_q;
        update     = 1'b0;

        if (cfg_in && !play_in) cfg_d = cfg_reg_in[3:0];

        rd_d    = flush ? '0 : rd_q + (AW+1)'(pop);
        wr_base = flush ? '0 : wr_q;
        if (push) mem_d[wr_base[AW-1:0]] = audio_in;
        wr_d    = wr_base + (AW+1)'(push);

        if (!play_in) begin
            cnt_d   = '0;
            b_d     = '0;
            frame_d = '0;
            lj_d    = 1'b0;
            sck_d   = 1'b0;
            ws_d    = 1'b0;
            sdo_d   = 1'b0;
        end else if (start) begin
            cnt_d      = '0;
            b_d        = '0;
            sck_d      = 1'b0;
            frame_d    = pop ? mem_q[rd_q[AW-1:0]] : '0;
            req_d      = 1'b1;
            underrun_d = empty;
            update     = 1'b1;
        end else if (fall) begin
            cnt_d  = '0;
            b_d    = b_q + 1'b1;
            sck_d  = 1'b0;
            update = 1'b1;
        end else begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == half_m1) sck_d = 1'b1;
        end

        // I2S emits the previous LJ bit, giving the one-sck data delay
        if (update) begin
            lj_d  = ser_bit(frame_d, b_d);
            ws_d  = mode_tdm ? (b_d == '0) : (b_d >= BW'(FRAME / 2));
            sdo_d = mode_i2s ? lj_q : lj_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cfg_q      <= '0;
            play_q     <= 1'b0;
            cnt_q      <= '0;
            b_q        <= '0;
            frame_q    <= '0;
            lj_q       <= 1'b0;
            sck_q      <= 1'b0;
            ws_q       <= 1'b0;
            sdo_q      <= 1'b0;
            req_q      <= 1'b0;
            underrun_q <= 1'b0;
            overflow_q <= 1'b0;
            wr_q       <= '0;
            rd_q       <= '0;
            mem_q      <= '{default: '0};
        end else begin
            cfg_q      <= cfg_d;
            play_q     <= play_d;
            cnt_q      <= cnt_d;
            b_q        <= b_d;
            frame_q    <= frame_d;
            lj_q       <= lj_d;
            sck_q      <= sck_d;
            ws_q       <= ws_d;
            sdo_q      <= sdo_d;
            req_q      <= req_d;
            underrun_q <= underrun_d;
            overflow_q <= overflow_d;
            wr_q       <= wr_d;
            rd_q       <= rd_d;
            mem_q      <= mem_d;
        end
    end

    assign req_out      = req_q;
    assign sck_out      = sck_q;
    assign ws_out       = ws_q;
    assign sdo_out      = sdo_q;
    assign underrun_out = underrun_q;
    assign overflow_out = overflow_q;
endmodule
